spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_gen.sv | 39 +++
 rtl/spi_master.sv | 142 ++++++++++++++
 tb/tb_spi_master.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and command-word field layout,
// reused by both the master and the device-side model.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT_CMD  = 3'd1,
    SHIFT_DATA = 3'd2,
    HOLD       = 3'd3,
    GAP        = 3'd4
  } spi_state_t;

  // Command word = {zero-fill, addr, dir}
  localparam int CMD_DIR_BIT  = 0;
  localparam int CMD_ADDR_LSB = 1;

endpackage

// File: rtl/spi_clk_gen.sv
// Divides sys_clk by CLK_DIV into a phase tick, rise/fall strobes for the
// next edge of spi_clk, and the registered spi_clk itself.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic toggle,
  output logic spi_clk,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;

  // Strobes are true in the cycle whose closing edge changes spi_clk.
  assign tick = run && (div_cnt == CW'(CLK_DIV - 1));
  assign rise = tick && toggle && !spi_clk;
  assign fall = tick && toggle && spi_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      spi_clk <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      spi_clk <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (rise)      spi_clk <= 1'b1;
      else if (fall) spi_clk <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: one command phase then one data phase per frame, LSB first,
// followed by a select-hold period and an inter-frame gap.
module spi_master
  import spi_pkg::*;
#(
  parameter int SPI_CMD_WIDTH  = 8,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int SPI_ADDR_WIDTH = 3,
  parameter int CLK_DIV        = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      start,
  input  logic                      cmd_dir,
  input  logic [SPI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [SPI_DATA_WIDTH-1:0] wr_data,
  output logic [SPI_DATA_WIDTH-1:0] rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      spi_clk,
  output logic                      spi_sel,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  localparam int CMDW  = SPI_CMD_WIDTH;
  localparam int DATW  = SPI_DATA_WIDTH;
  localparam int BMAX  = (CMDW > DATW) ? CMDW : DATW;
  localparam int BW    = (BMAX > 1) ? $clog2(BMAX) : 1;

  spi_state_t state, state_nxt;

  logic [BW-1:0]   bit_cnt;
  logic [CMDW-1:0] cmd_word, cmd_sr, cmd_nxt;
  logic [DATW-1:0] data_sr, data_nxt;
  logic            dir_q;
  logic            run, shifting, tick, rise, fall;
  logic            last_cmd, last_data;

  assign run       = (state != IDLE);
  assign shifting  = (state == SHIFT_CMD) || (state == SHIFT_DATA);
  assign last_cmd  = (bit_cnt == BW'(CMDW - 1));
  assign last_data = (bit_cnt == BW'(DATW - 1));
  assign cmd_nxt   = cmd_sr >> 1;
  assign data_nxt  = data_sr >> 1;

  always_comb begin
    cmd_word = '0;
    cmd_word[CMD_DIR_BIT] = cmd_dir;
    cmd_word[CMD_ADDR_LSB +: SPI_ADDR_WIDTH] = cmd_addr;
  end

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .run    (run),
    .toggle (shifting),
    .spi_clk(spi_clk),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start)             state_nxt = SHIFT_CMD;
      SHIFT_CMD:  if (fall && last_cmd)  state_nxt = SHIFT_DATA;
      SHIFT_DATA: if (fall && last_data) state_nxt = HOLD;
      HOLD:       if (tick)              state_nxt = GAP;
      GAP:        if (tick)              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // The divider phase counter keeps wrapping through HOLD and GAP, so each
  // of them lasts exactly one tick period.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt  <= '0;
      cmd_sr   <= '0;
      data_sr  <= '0;
      dir_q    <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_sel  <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dir_q    <= cmd_dir;
          cmd_sr   <= cmd_word;
          data_sr  <= wr_data;
          bit_cnt  <= '0;
          spi_mosi <= cmd_word[0];
          spi_sel  <= 1'b0;
          busy     <= 1'b1;
        end
        SHIFT_CMD: if (fall) begin
          if (last_cmd) begin
            bit_cnt  <= '0;
            spi_mosi <= dir_q & data_sr[0];
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            cmd_sr   <= cmd_nxt;
            spi_mosi <= cmd_nxt[0];
          end
        end
        SHIFT_DATA: begin
          // Read frames reuse the payload register as the receive shifter.
          if (rise && !dir_q)
            data_sr <= data_nxt | (DATW'(spi_miso) << (DATW - 1));
          if (fall) begin
            if (last_data) begin
              bit_cnt  <= '0;
              spi_mosi <= 1'b0;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              spi_mosi <= dir_q & data_nxt[0];
              if (dir_q) data_sr <= data_nxt;
            end
          end
        end
        HOLD: if (tick) begin
          spi_sel <= 1'b1;
          done    <= 1'b1;
          if (!dir_q) rd_data <= data_sr;
        end
        GAP: if (tick) busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a default instance exercised with writes, reads,
// ignored starts and mid-frame reset, plus a CLK_DIV=1 / 16-bit instance run back-to-back.
module tb_spi_master;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       start, cmd_dir, spi_miso;
  logic [2:0] cmd_addr;
  logic [7:0] wr_data, rd_data;
  logic       busy, done, spi_clk, spi_sel, spi_mosi;

  spi_master dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .done(done), .spi_clk(spi_clk), .spi_sel(spi_sel), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  logic        start_b, cmd_dir_b, spi_miso_b;
  logic [2:0]  cmd_addr_b;
  logic [15:0] wr_data_b, rd_data_b;
  logic        busy_b, done_b, spi_clk_b, spi_sel_b, spi_mosi_b;

  spi_master #(.SPI_DATA_WIDTH(16), .CLK_DIV(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_b), .cmd_dir(cmd_dir_b),
    .cmd_addr(cmd_addr_b), .wr_data(wr_data_b), .rd_data(rd_data_b), .busy(busy_b),
    .done(done_b), .spi_clk(spi_clk_b), .spi_sel(spi_sel_b), .spi_mosi(spi_mosi_b),
    .spi_miso(spi_miso_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboards
  logic [15:0] exp_q[$];
  logic [7:0]  rd_q[$];
  logic [23:0] expb_q[$];
  logic [7:0]  dev_val;
  logic [7:0]  exp_rd = 8'h00;

  // monitor / device model for the default instance
  logic [15:0] cap;
  int          nrise;
  logic        pclk, psel, pmosi;
  int          viol = 0;
  int          done_cnt = 0;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      cap = '0; nrise = 0; spi_miso = 1'b0; pclk = 1'b0; psel = 1'b1; pmosi = 1'b0;
    end else begin
      if (psel && !spi_sel) begin cap = '0; nrise = 0; end
      if (spi_clk && !pclk && !spi_sel) begin
        if (nrise < 16) cap[nrise] = spi_mosi;
        nrise++;
      end
      if (!spi_clk && pclk)
        spi_miso = (nrise >= 8 && nrise < 16) ? dev_val[nrise-8] : 1'b0;
      if (!spi_sel && !psel && spi_mosi !== pmosi && !(pclk && !spi_clk)) viol++;
      if (spi_sel && !psel) begin
        chk("nbits", nrise, 16);
        if (exp_q.size() == 0) chk("frame_unexp", exp_q.size(), 1);
        else chk("frame_bits", cap, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (rd_q.size() == 0) chk("done_unexp", rd_q.size(), 1);
        else chk("rd_data", rd_data, rd_q.pop_front());
      end
      pclk = spi_clk; psel = spi_sel; pmosi = spi_mosi;
    end
  end

  // monitor for the fast instance
  logic [23:0] cap_b;
  int          nr_b, gap_b;
  int          frames_b = 0;
  logic        pclk_b, psel_b;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      cap_b = '0; nr_b = 0; gap_b = 0; pclk_b = 1'b0; psel_b = 1'b1;
    end else begin
      if (psel_b && !spi_sel_b) begin
        if (frames_b > 0) chk("b_gap", gap_b, 2);
        cap_b = '0; nr_b = 0;
      end else if (spi_sel_b) gap_b++;
      if (spi_clk_b && !pclk_b && !spi_sel_b) begin
        if (nr_b < 24) cap_b[nr_b] = spi_mosi_b;
        nr_b++;
      end
      if (spi_sel_b && !psel_b) begin
        chk("b_nbits", nr_b, 24);
        if (expb_q.size() == 0) chk("b_frame_unexp", expb_q.size(), 1);
        else chk("b_frame_bits", cap_b, expb_q.pop_front());
        frames_b++;
        gap_b = 1;
      end
      pclk_b = spi_clk_b; psel_b = spi_sel_b;
    end
  end

  // Called just after a negedge; start is sampled on the following posedge.
  task automatic run_frame(input logic dir, input logic [2:0] addr, input logic [7:0] data,
                           input int poke_at, input int rst_at);
    int n, busy_n, done_at, d0;
    bit aborted;
    cmd_dir = dir; cmd_addr = addr; wr_data = data; start = 1'b1;
    exp_q.push_back({dir ? data : 8'h00, 4'b0000, addr, dir});
    if (!dir) exp_rd = dev_val;
    rd_q.push_back(exp_rd);
    d0 = done_cnt;
    @(negedge sys_clk);
    cmd_dir = ~dir; cmd_addr = ~addr; wr_data = ~data;
    n = 1; busy_n = 0; done_at = -1; aborted = 0;
    while (1) begin
      if (rst_at != 0 && n == rst_at) begin
        #2 sys_rst_n = 1'b0;
        #1 chk("rst_sel", spi_sel, 1'b1);
        chk("rst_clk", spi_clk, 1'b0);
        aborted = 1;
        break;
      end
      if (!busy) break;
      busy_n++;
      if (done) done_at = n;
      start = (poke_at != 0 && n == poke_at);
      if (n >= 400) break;
      @(negedge sys_clk);
      n++;
    end
    start = 1'b0;
    if (aborted) begin
      repeat (3) @(negedge sys_clk);
      void'(exp_q.pop_back());
      void'(rd_q.pop_back());
      exp_rd = 8'h00;
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_no_done", done_cnt - d0, 0);
      sys_rst_n = 1'b1;
    end else begin
      chk("busy_len", busy_n, 136);
      chk("done_at", done_at, 133);
      chk("done_cnt", done_cnt - d0, 1);
    end
  endtask

  logic [15:0] datb [4];

  initial begin
    start = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; wr_data = '0; dev_val = 8'h3C;
    start_b = 1'b0; cmd_dir_b = 1'b1; cmd_addr_b = 3'd6; wr_data_b = '0; spi_miso_b = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_sel0", spi_sel, 1'b1);
    chk("rst_clk0", spi_clk, 1'b0);
    chk("rst_mosi0", spi_mosi, 1'b0);
    chk("rst_busy0", busy, 1'b0);
    chk("rst_done0", done, 1'b0);
    chk("rst_rd0", rd_data, 8'h00);
    sys_rst_n = 1'b1;

    run_frame(1'b1, 3'd5, 8'hA5, 0, 0);
    run_frame(1'b0, 3'd2, 8'h77, 0, 0);
    run_frame(1'b1, 3'd1, 8'h5A, 50, 0);
    chk("rd_keep1", rd_data, 8'h3C);
    dev_val = 8'h96;
    run_frame(1'b0, 3'd7, 8'h00, 0, 40);
    dev_val = 8'h3C;
    run_frame(1'b0, 3'd2, 8'h00, 0, 0);
    run_frame(1'b1, 3'd4, 8'hFF, 0, 0);
    chk("rd_keep2", rd_data, 8'h3C);

    // back-to-back frames with start held high
    datb[0] = 16'h1234; datb[1] = 16'hBEEF; datb[2] = 16'h8001; datb[3] = 16'hFFFF;
    for (int k = 0; k < 4; k++) expb_q.push_back({datb[k], 8'h0D});
    wr_data_b = datb[0];
    start_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int t;
      t = 0;
      @(negedge sys_clk);
      while (!done_b && t < 200) begin
        @(negedge sys_clk);
        t++;
      end
      chk("b_done_wait", (t < 200), 1);
      if (k < 3) wr_data_b = datb[k+1];
      else start_b = 1'b0;
    end
    repeat (10) @(negedge sys_clk);
    chk("b_frames", frames_b, 4);
    chk("b_idle", busy_b, 1'b0);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("expb_q_empty", expb_q.size(), 0);
    chk("mosi_stable", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
